// File: rtl/dfswt_peak_tracker.sv
// -----------------------------------------------------------------------------
// dfswt_peak_tracker
//
// Picks the strongest bin of each serially streamed magnitude frame and
// reports it with hysteresis and hold-over, so the reported bin does not
// chatter between neighbouring bins or drop out on a single weak frame.
//
// Ports:
//   clock        system clock
//   reset        synchronous, active-high reset
//   enable       global advance; when low all state and the pipeline freeze
//   mag_valid    mag_data valid this cycle (qualified by enable)
//   mag_data     signed magnitude of the current bin
//   mag_last     marks the final bin of a frame (qualified by mag_valid)
//   threshold    signed detection threshold, sampled with bin 0
//   peak_valid   one-cycle pulse per completed good frame
//   peak_found   a peak is currently held
//   peak_bin     held peak bin index
//   peak_mag     held peak bin magnitude from the latest frame
//   frame_error  one-cycle pulse on a frame-length violation
// -----------------------------------------------------------------------------
module dfswt_peak_tracker #(
    parameter int BINS        = 16,
    parameter int LOG         = 4,
    parameter int WIDTH       = 32,
    parameter int HYST_SHIFT  = 3,
    parameter int HOLD_FRAMES = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    mag_valid,
    input  logic signed [WIDTH-1:0] mag_data,
    input  logic                    mag_last,
    input  logic signed [WIDTH-1:0] threshold,
    output logic                    peak_valid,
    output logic                    peak_found,
    output logic [LOG-1:0]          peak_bin,
    output logic signed [WIDTH-1:0] peak_mag,
    output logic                    frame_error
);

    typedef enum logic {SCAN, DRAIN} state_t;

    localparam int             MISS_W   = $clog2(HOLD_FRAMES + 1);
    localparam logic [LOG-1:0] LAST_BIN = LOG'(BINS - 1);
    localparam logic [MISS_W-1:0] MISS_MAX = MISS_W'(HOLD_FRAMES);

    state_t                    state;
    logic [LOG-1:0]            bin_cnt;
    logic [MISS_W-1:0]         miss_cnt;

    // Running scan of the current frame. best is loaded from threshold on
    // bin 0 and only ever rises, so it doubles as the latched threshold.
    logic signed [WIDTH-1:0]   best;
    logic                      cand_valid;
    logic [LOG-1:0]            cand_bin;
    logic signed [WIDTH-1:0]   cur_held;

    // Report stage: one completed frame waiting for its decision.
    logic                      rpt_pending;
    logic                      rpt_cand_valid;
    logic [LOG-1:0]            rpt_cand_bin;
    logic signed [WIDTH-1:0]   rpt_cand_mag;
    logic signed [WIDTH-1:0]   rpt_cur_held;

    // Scan results including the sample on the bus this cycle.
    logic                      first_bin;
    logic signed [WIDTH-1:0]   best_ref;
    logic                      beats;
    logic                      f_valid;
    logic [LOG-1:0]            f_bin;
    logic signed [WIDTH-1:0]   f_mag;
    logic signed [WIDTH-1:0]   f_held;

    // Decision terms for the report stage.
    logic signed [WIDTH:0]     held_ext;
    logic signed [WIDTH:0]     cand_ext;
    logic signed [WIDTH:0]     margin;
    logic                      switch_ok;
    logic [MISS_W-1:0]         miss_inc;

    // NOTE: every always_comb output gets a value on every path (here by
    // direct assignment), otherwise synthesis infers a latch.
    always_comb begin
        first_bin = (bin_cnt == '0);
        best_ref  = first_bin ? threshold : best;
        // Strictly greater: ties keep the lower (earlier) index.
        beats     = (mag_data > best_ref);
        f_valid   = beats | (cand_valid & ~first_bin);
        f_bin     = beats ? bin_cnt  : cand_bin;
        f_mag     = beats ? mag_data : best_ref;
        if (bin_cnt == peak_bin) begin
            f_held = mag_data;
        end else begin
            f_held = first_bin ? '0 : cur_held;
        end

        // Hysteresis in WIDTH+1 bits so cur_held + cur_held/8 cannot wrap.
        held_ext  = {rpt_cur_held[WIDTH-1], rpt_cur_held};
        cand_ext  = {rpt_cand_mag[WIDTH-1], rpt_cand_mag};
        margin    = held_ext + (held_ext >>> HYST_SHIFT);
        switch_ok = (cand_ext > margin);

        miss_inc  = (miss_cnt == MISS_MAX) ? miss_cnt : miss_cnt + 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    // NOTE: the reset clears the data registers too; they are few and it
    // keeps the post-reset outputs fully defined.
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= SCAN;
            bin_cnt        <= '0;
            miss_cnt       <= '0;
            best           <= '0;
            cand_valid     <= 1'b0;
            cand_bin       <= '0;
            cur_held       <= '0;
            rpt_pending    <= 1'b0;
            rpt_cand_valid <= 1'b0;
            rpt_cand_bin   <= '0;
            rpt_cand_mag   <= '0;
            rpt_cur_held   <= '0;
            peak_valid     <= 1'b0;
            peak_found     <= 1'b0;
            peak_bin       <= '0;
            peak_mag       <= '0;
            frame_error    <= 1'b0;
        end else begin
            // Pulses last exactly one cycle and are never issued while frozen.
            peak_valid  <= 1'b0;
            frame_error <= 1'b0;

            if (enable) begin
                if (rpt_pending) begin
                    rpt_pending <= 1'b0;
                    peak_valid  <= 1'b1;
                    if (!rpt_cand_valid) begin
                        miss_cnt <= miss_inc;
                        if (miss_inc == MISS_MAX) begin
                            peak_found <= 1'b0;
                        end else begin
                            peak_mag <= rpt_cur_held;
                        end
                    end else begin
                        miss_cnt <= '0;
                        if (!peak_found || rpt_cand_bin == peak_bin || switch_ok) begin
                            peak_found <= 1'b1;
                            peak_bin   <= rpt_cand_bin;
                            peak_mag   <= rpt_cand_mag;
                        end else begin
                            peak_mag <= rpt_cur_held;
                        end
                    end
                end

                if (mag_valid) begin
                    case (state)
                        SCAN: begin
                            if (mag_last && bin_cnt == LAST_BIN) begin
                                // Loading here overrides the clear above, so
                                // back-to-back frames never lose a report.
                                rpt_pending    <= 1'b1;
                                rpt_cand_valid <= f_valid;
                                rpt_cand_bin   <= f_bin;
                                rpt_cand_mag   <= f_mag;
                                rpt_cur_held   <= f_held;
                                bin_cnt        <= '0;
                            end else if (mag_last) begin
                                frame_error <= 1'b1;
                                bin_cnt     <= '0;
                            end else if (bin_cnt == LAST_BIN) begin
                                frame_error <= 1'b1;
                                state       <= DRAIN;
                            end else begin
                                best       <= f_mag;
                                cand_valid <= f_valid;
                                cand_bin   <= f_bin;
                                cur_held   <= f_held;
                                bin_cnt    <= bin_cnt + 1'b1;
                            end
                        end
                        DRAIN: begin
                            if (mag_last) begin
                                state   <= SCAN;
                                bin_cnt <= '0;
                            end
                        end
                        default: state <= SCAN;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_dfswt_peak_tracker.sv
// -----------------------------------------------------------------------------
// Scoreboard bench for dfswt_peak_tracker (BINS=8, HYST_SHIFT=3,
// HOLD_FRAMES=2, threshold=100). The driver pushes hand-computed expected
// reports (with the enabled-edge count at which each pulse must appear);
// a monitor on the falling edge pops and compares whenever a pulse shows.
// -----------------------------------------------------------------------------
module tb_dfswt_peak_tracker;

    localparam int BINS  = 8;
    localparam int LOG   = 3;
    localparam int WIDTH = 32;

    logic                    clock = 1'b0;
    logic                    reset;
    logic                    enable;
    logic                    mag_valid;
    logic signed [WIDTH-1:0] mag_data;
    logic                    mag_last;
    logic signed [WIDTH-1:0] threshold;
    logic                    peak_valid;
    logic                    peak_found;
    logic [LOG-1:0]          peak_bin;
    logic signed [WIDTH-1:0] peak_mag;
    logic                    frame_error;

    dfswt_peak_tracker #(
        .BINS(BINS), .LOG(LOG), .WIDTH(WIDTH), .HYST_SHIFT(3), .HOLD_FRAMES(2)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .mag_valid(mag_valid), .mag_data(mag_data), .mag_last(mag_last),
        .threshold(threshold), .peak_valid(peak_valid), .peak_found(peak_found),
        .peak_bin(peak_bin), .peak_mag(peak_mag), .frame_error(frame_error)
    );

    always #5 clock = ~clock;

    typedef enum logic {EV_PEAK, EV_ERR} ev_t;
    typedef struct {
        string                   tag;
        ev_t                     kind;
        int                      due;
        logic                    found;
        logic [LOG-1:0]          bin;
        logic signed [WIDTH-1:0] mag;
    } exp_t;

    exp_t q[$];
    int   total    = 0;
    int   bad      = 0;
    int   edge_cnt = 0;
    bit   toggle   = 1'b0;
    logic signed [WIDTH-1:0] fr [BINS];

    // Enabled, non-reset edges; latency expectations are in these units.
    always @(posedge clock) if (enable && !reset) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input logic en, input logic v, input logic signed [WIDTH-1:0] d,
                       input logic l);
        enable    = en;
        mag_valid = v;
        mag_data  = d;
        mag_last  = l;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b1, 1'b0, 0, 1'b0);
    endtask

    // In toggle mode each sample is preceded by a frozen cycle carrying junk.
    task automatic send(input logic signed [WIDTH-1:0] d, input logic l);
        if (toggle) cyc(1'b0, 1'b1, 32'sd7777, 1'b1);
        cyc(1'b1, 1'b1, d, l);
    endtask

    task automatic send_frame();
        for (int i = 0; i < BINS; i++) send(fr[i], i == BINS - 1);
    endtask

    // Called right after the last-bin accept: report visible after one more
    // enabled edge.
    task automatic push_peak(input string tag, input logic f, input logic [LOG-1:0] b,
                             input logic signed [WIDTH-1:0] m);
        exp_t e;
        e.tag = tag; e.kind = EV_PEAK; e.due = edge_cnt + 1;
        e.found = f; e.bin = b; e.mag = m;
        q.push_back(e);
    endtask

    // Called right after the offending accept: pulse visible straight away.
    task automatic push_err(input string tag);
        exp_t e;
        e.tag = tag; e.kind = EV_ERR; e.due = edge_cnt;
        e.found = 1'b0; e.bin = '0; e.mag = '0;
        q.push_back(e);
    endtask

    task automatic handle(input ev_t k);
        exp_t e;
        if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL spurious_pulse: got kind %0d at edge %0d expected none", k, edge_cnt);
        end else begin
            e = q.pop_front();
            check({e.tag, "_kind"}, k, e.kind);
            check({e.tag, "_latency"}, edge_cnt, e.due);
            if (k == EV_PEAK && e.kind == EV_PEAK) begin
                check({e.tag, "_found"}, peak_found, e.found);
                if (e.found) begin
                    check({e.tag, "_bin"}, peak_bin, e.bin);
                    check({e.tag, "_mag"}, peak_mag, e.mag);
                end
            end
        end
    endtask

    always @(negedge clock) begin
        if (peak_valid)  handle(EV_PEAK);
        if (frame_error) handle(EV_ERR);
    end

    task automatic check_zero(input string tag);
        check({tag, "_peak_valid"},  peak_valid,  0);
        check({tag, "_peak_found"},  peak_found,  0);
        check({tag, "_peak_bin"},    peak_bin,    0);
        check({tag, "_peak_mag"},    peak_mag,    0);
        check({tag, "_frame_error"}, frame_error, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        threshold = 100;
        reset     = 1'b1;
        cyc(1'b0, 1'b0, 0, 1'b0);
        cyc(1'b0, 1'b0, 0, 1'b0);
        reset = 1'b0;
        check_zero("reset");

        // Tie at 300 keeps bin 2; frames run back-to-back.
        fr = '{0, 50, 300, 20, 300, 0, 0, 0};
        send_frame(); push_peak("tie", 1'b1, 3'd2, 300);
        fr = '{0, 0, 400, 0, 0, 440, 0, 0};
        send_frame(); push_peak("hyst_keep", 1'b1, 3'd2, 400);
        fr = '{0, 0, 400, 0, 0, 451, 0, 0};
        send_frame(); push_peak("hyst_switch", 1'b1, 3'd5, 451);

        // Two empty frames: the first holds (mag from bin 5), the second drops.
        fr = '{100, 100, 100, 100, 100, 100, 100, 100};
        send_frame(); push_peak("miss1", 1'b1, 3'd5, 100);
        send_frame(); push_peak("miss2", 1'b0, 3'd0, 0);
        idle(3);

        // Short frame: mag_last on the 5th sample.
        send(7000, 1'b0); send(0, 1'b0); send(0, 1'b0); send(0, 1'b0);
        send(7000, 1'b1); push_err("short");
        idle(2);
        fr = '{0, 0, 0, 500, 0, 0, 0, 0};
        send_frame(); push_peak("after_short", 1'b1, 3'd3, 500);
        idle(3);

        // Long frame: error on the 8th sample, drain until mag_last.
        for (int i = 0; i < 10; i++) begin
            send((i == 1) ? 5000 : ((i >= 8) ? 9999 : 0), 1'b0);
            if (i == 7) push_err("long");
        end
        send(9999, 1'b1);
        idle(2);
        fr = '{0, 0, 0, 0, 0, 0, 200, 0};
        send_frame(); push_peak("after_drain", 1'b1, 3'd6, 200);
        idle(3);

        // Enable toggling; the second report waits through frozen cycles.
        toggle = 1'b1;
        fr = '{0, 250, 0, 0, 0, 0, 300, 0};
        send_frame(); push_peak("tog_a", 1'b1, 3'd6, 300);
        fr = '{120, 0, 0, 0, 0, 0, 0, 0};
        send_frame(); push_peak("tog_b", 1'b1, 3'd0, 120);
        cyc(1'b0, 1'b0, 0, 1'b0);
        cyc(1'b0, 1'b0, 0, 1'b0);
        cyc(1'b0, 1'b0, 0, 1'b0);
        toggle = 1'b0;
        idle(3);

        // Reset in the middle of a frame.
        send(0, 1'b0); send(9000, 1'b0); send(0, 1'b0);
        reset = 1'b1;
        cyc(1'b1, 1'b1, 0, 1'b0);
        check_zero("mid_reset");
        reset = 1'b0;
        fr = '{0, 0, 0, 0, 150, 0, 0, 0};
        send_frame(); push_peak("post_reset", 1'b1, 3'd4, 150);
        idle(4);

        check("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dfswt_peak_tracker.md
Name: dfswt_peak_tracker

Overview:
- Parametrised successor to the sliding-DFT max-bin selector.
- Consumes per-bin magnitudes streamed serially, one bin per accepted sample, frame by frame.
- Finds the strongest bin per frame against a threshold, then applies hysteresis and a hold-over so the reported bin does not chatter.
- Sits between the dfswt accumulator bank (serialised) and downstream direction/frequency logic.

Parameters:
- BINS, 16, bins per frame (power of two, >= 4)
- LOG, 4, log2(BINS); width of bin indices
- WIDTH, 32, signed magnitude width
- HYST_SHIFT, 3, switching margin = held-bin current magnitude >> HYST_SHIFT
- HOLD_FRAMES, 4, consecutive below-threshold frames before the peak is dropped (>= 1)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  global advance; when 0 all state and the pipeline freeze
- mag_valid  in  1  mag_data valid this cycle (qualified by enable)
- mag_data  in  WIDTH  signed magnitude of current bin
- mag_last  in  1  marks final bin of frame (qualified by mag_valid)
- threshold  in  WIDTH  signed detection threshold
- peak_valid  out  1  one-cycle pulse per completed good frame
- peak_found  out  1  a peak is currently held
- peak_bin  out  LOG  held peak bin index
- peak_mag  out  WIDTH  held peak bin magnitude from the latest frame
- frame_error  out  1  one-cycle pulse on frame-length violation

Behaviour:
- Interface: one clock, reset is synchronous and active-high; ports named clock and reset.
- Reset values: all outputs 0; bin_cnt=0; state=SCAN; miss_cnt=0; pipeline stage empty.
- Accept = enable & mag_valid. Internal bin_cnt gives the index of each accepted sample and increments per accept.
- threshold is latched on the accept with bin_cnt=0 and used for the whole frame.
- SCAN state:
  - best starts at the latched threshold with no candidate.
  - A sample becomes the candidate if strictly greater (signed) than the current best. Ties keep the lower index. Values <= threshold are never candidates.
  - Also records cur_held = mag_data at bin_cnt == peak_bin.
- Frame end on accept with mag_last=1 and bin_cnt=BINS-1: load candidate, cur_held and found flag into the report stage; bin_cnt <= 0.
- mag_last=1 with bin_cnt != BINS-1: frame_error pulses the next cycle; frame discarded; bin_cnt <= 0; stay in SCAN.
- Accept at bin_cnt=BINS-1 with mag_last=0: frame_error pulses; frame discarded; go to DRAIN.
- DRAIN state: drop accepts until an accept with mag_last=1, then bin_cnt <= 0 and return to SCAN. That sample is not counted.
- Report stage: fires on the first enabled edge after frame end. Outputs update and peak_valid=1 in the cycle after it. Latency is 2 enabled edges from the last-bin accept. The stage never stalls input; bin 0 of the next frame may be accepted back-to-back.
- Decision logic:
  - No candidate: miss_cnt++ (saturating). If miss_cnt reaches HOLD_FRAMES, clear peak_found. Otherwise hold peak_bin and set peak_mag <= cur_held.
  - Candidate and (!peak_found or cand_bin == peak_bin): take candidate; miss_cnt=0.
  - Candidate, different bin: switch only if cand_mag > cur_held + (cur_held >>> HYST_SHIFT). Compute in WIDTH+1 bits, no overflow. Otherwise keep peak_bin and set peak_mag <= cur_held. miss_cnt=0 in both cases.
- enable=0: nothing changes and no pulses are issued; a pending report stays pending.
- Reset mid-frame or mid-report discards everything and returns to reset values on the next edge.

Test Plan:
- Setup for all tests: BINS=8, LOG=3, WIDTH=32, HYST_SHIFT=3, HOLD_FRAMES=2, threshold=100.
- Frame {0,50,300,20,300,0,0,0} -> peak_valid 2 cycles after last bin; peak_bin=2, peak_mag=300, peak_found=1 (tie keeps lower index).
- Held bin 2. Next frame bin2=400, bin5=440 -> bin 5 not > 450, so peak_bin=2, peak_mag=400. Next frame bin2=400, bin5=451 -> peak_bin=5, peak_mag=451.
- Two frames all <= 100 after a peak -> first keeps peak_found=1; second clears peak_found; peak_valid pulses both times.
- mag_last on 5th sample -> frame_error pulse, no peak_valid; next good 8-bin frame reports normally.
- 10 samples with no mag_last, then a last sample, then a good frame -> one frame_error, drained samples ignored, good frame reported.
- Back-to-back frames with enable toggling 0/1 every other cycle -> results identical to continuous enable. Reset asserted mid-frame -> all outputs 0 the next cycle; the partial frame is never reported.
